inst_mem_responder: RTL

// Server end of MemIntf: pipelined, in-order word memory answering the fetch unit's read stream
// (and LSU writes) with fixed, parameterised latency and buffered responses under backpressure.

---
 rtl/inst_mem_responder_pkg.sv | 32 +++
 rtl/inst_mem_responder_if.sv | 23 ++
 rtl/inst_mem_responder_resp_fifo.sv | 49 ++++
 rtl/inst_mem_responder.sv | 125 ++++++++++++
 4 files changed

// File: rtl/inst_mem_responder_pkg.sv
// Shared MemIntf message types for the memory responder and its clients.
// Carries the request/response record and a byte-lane merge helper.
package inst_mem_responder_pkg;

    localparam int MEM_OPAQUE_W = 8;

    typedef enum logic {
        MEM_MSG_READ  = 1'b0,
        MEM_MSG_WRITE = 1'b1
    } mem_msg_type_t;

    typedef struct packed {
        mem_msg_type_t           op;
        logic [MEM_OPAQUE_W-1:0] opaque;
        logic [31:0]             addr;
        logic [3:0]              strb;
        logic [31:0]             data;
    } mem_msg_t;

    // Replace only the byte lanes selected by strb.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/inst_mem_responder_if.sv
// MemIntf val/rdy request and response channels between a client and the memory.
// The client drives requests through master; the memory answers through slave.
interface inst_mem_responder_if;
    import inst_mem_responder_pkg::*;

    logic     req_val;
    logic     req_rdy;
    mem_msg_t req_msg;
    logic     resp_val;
    logic     resp_rdy;
    mem_msg_t resp_msg;

    modport master (
        output req_val, req_msg, resp_rdy,
        input  req_rdy, resp_val, resp_msg
    );

    modport slave (
        input  req_val, req_msg, resp_rdy,
        output req_rdy, resp_val, resp_msg
    );

endinterface

// File: rtl/inst_mem_responder_resp_fifo.sv
// Shift-register response FIFO whose head always sits in entry 0 (registered output).
// The upstream credit counter guarantees an enqueue never arrives when full.
module mem_resp_fifo #(
    parameter int  p_depth = 4,
    parameter type msg_t   = logic [31:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic enq_val,
    input  msg_t enq_msg,
    output logic deq_val,
    input  logic deq_rdy,
    output msg_t deq_msg
);

    localparam int CW = $clog2(p_depth + 1);

    msg_t          entries [p_depth];
    logic [CW-1:0] count;
    logic [CW-1:0] wr_pos;
    logic          do_deq;

    assign deq_val = (count != '0);
    assign deq_msg = entries[0];
    assign do_deq  = deq_val & deq_rdy;
    // A same-cycle dequeue shifts everything down, so the new entry lands one slot lower.
    assign wr_pos  = do_deq ? (count - CW'(1)) : count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (enq_val && !do_deq) begin
            count <= count + CW'(1);
        end else if (!enq_val && do_deq) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < p_depth; i++) begin
            if (enq_val && (wr_pos == CW'(i))) begin
                entries[i] <= enq_msg;
            end else if (do_deq) begin
                entries[i] <= entries[(i < p_depth - 1) ? i + 1 : i];
            end
        end
    end

endmodule

// File: rtl/inst_mem_responder.sv
// Pipelined in-order word memory serving MemIntf reads and byte-strobed writes
// with a fixed accept-to-response latency and credit-limited buffering.
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter int          p_latency   = 2,
    parameter int          p_depth     = 4,
    parameter int          p_words     = 1024,
    parameter logic [31:0] p_base_addr = 32'h200
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_mem_responder_if.slave  mem
);

    localparam int IW = (p_words > 1) ? $clog2(p_words) : 1;
    localparam int FW = $clog2(p_depth) + 1;

    logic [31:0]   words [p_words];
    logic          req_xfer;
    logic          resp_xfer;
    logic [FW-1:0] in_flight;
    logic [31:0]   offset;
    logic [31:0]   word_off;
    logic          in_range;
    logic [IW-1:0] index;
    mem_msg_t      resp_p0;
    logic          enq_val;
    mem_msg_t      enq_msg;

    assign req_xfer  = mem.req_val & mem.req_rdy;
    assign resp_xfer = mem.resp_val & mem.resp_rdy;
    // Credit is derived from the counter register alone, never from resp_rdy.
    assign mem.req_rdy = (in_flight < FW'(p_depth));

    assign offset   = mem.req_msg.addr - p_base_addr;
    assign word_off = offset >> 2;
    assign in_range = (mem.req_msg.addr >= p_base_addr) && (word_off < 32'(p_words));
    assign index    = word_off[IW-1:0];

    // Stage p0: array access in the accept cycle, so a later read sees an earlier write.
    always_comb begin
        resp_p0      = mem.req_msg;
        resp_p0.data = '0;
        if ((mem.req_msg.op == MEM_MSG_READ) && in_range) begin
            resp_p0.data = words[index];
        end
    end

    always_ff @(posedge clk) begin
        if (req_xfer && (mem.req_msg.op == MEM_MSG_WRITE) && in_range) begin
            words[index] <= merge_bytes(words[index], mem.req_msg.data, mem.req_msg.strb);
        end
    end

    generate
        if (p_latency <= 1) begin : g_no_dly
            assign enq_val = req_xfer;
            assign enq_msg = resp_p0;
        end else begin : g_dly
            localparam int N = p_latency - 1;

            logic [N-1:0] dly_val_p;
            mem_msg_t     dly_msg_p [N];

            // Stages p1..pN: fixed delay before the response buffer.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dly_val_p <= '0;
                end else begin
                    dly_val_p[0] <= req_xfer;
                    for (int i = 1; i < N; i++) begin
                        dly_val_p[i] <= dly_val_p[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                dly_msg_p[0] <= resp_p0;
                for (int i = 1; i < N; i++) begin
                    dly_msg_p[i] <= dly_msg_p[i-1];
                end
            end

            assign enq_val = dly_val_p[N-1];
            assign enq_msg = dly_msg_p[N-1];
        end
    endgenerate

    // Buffer stage: holds responses while the client stalls.
    mem_resp_fifo #(
        .p_depth (p_depth),
        .msg_t   (mem_msg_t)
    ) u_resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .enq_val (enq_val),
        .enq_msg (enq_msg),
        .deq_val (mem.resp_val),
        .deq_rdy (mem.resp_rdy),
        .deq_msg (mem.resp_msg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight <= '0;
        end else begin
            case ({req_xfer, resp_xfer})
                2'b10:   in_flight <= in_flight + FW'(1);
                2'b01:   in_flight <= in_flight - FW'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    function automatic string trace();
        string s_req;
        string s_resp;
        s_req  = req_xfer ? $sformatf("%08h", mem.req_msg.addr) : "        ";
        s_resp = resp_xfer ? $sformatf("%08h:%08h", mem.resp_msg.addr, mem.resp_msg.data)
                           : "                 ";
        return {s_req, " > ", s_resp};
    endfunction

endmodule
